keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Row-scanning reader for a 4x4 matrix keypad: drives one row low at a time, samples the
//  column lines, debounces, and reports one key code per press.
//  Input-side counterpart of the row-scanned dot-matrix driver.
//  Sits between the board keypad pins and the game control logic, which maps codes to
//  control words.
//  Runs on the same 10 kHz scan clock as the display.
// PARAMETERS
//  SCAN_DIV      10  clock cycles each row is driven (dwell); legal range >= 4
//  DEBOUNCE_CNT  4   consecutive matching samples needed to accept a press or a release; >= 1
// PORTS
//  clock        in   1  scan clock, 10 kHz nominal
//  reset        in   1  asynchronous, active-high reset
//  key_col      in   4  column sense lines, active-low (pulled up), asynchronous to clock
//  key_row      out  4  row drive, one-hot active-low; row r low = bit r is 0
//  key_code     out  4  last accepted key = row*4 + col
//  key_valid    out  1  one-cycle pulse when a new press is accepted
//  key_pressed  out  1  level; high from acceptance until the release is accepted
// BEHAVIOUR
//  Reset values: key_row=4'b1110 (row 0), key_code=0, key_valid=0, key_pressed=0.
//  Internal reset values: state=SCAN, div=0, row ptr=0, counters=0, synchroniser=4'b1111.
//  Synchroniser: key_col passes through 2 flops before use; call the result col_s.
//  Dwell counter: div counts 0..SCAN_DIV-1 and wraps; "sample" = the cycle with div==SCAN_DIV-1.
//  Row advance: only in SCAN/RELEASE->SCAN, on the cycle after a sample; row ptr wraps 3->0.
//    key_row updates on the same edge as the advance.
//  Hit: on a sample, col_s != 4'b1111. Candidate code = row*4 + lowest-index low column.
//  States:
//   SCAN:     on sample, hit -> cand=code, cnt=1, row frozen.
//             If DEBOUNCE_CNT==1 go straight to accept; else go DEBOUNCE.
//             No hit -> advance row.
//   DEBOUNCE: row frozen. On sample, same code -> cnt++.
//             When cnt reaches DEBOUNCE_CNT -> accept.
//             Different code or no hit -> SCAN and advance row; no output change.
//   accept:   on the edge after the accepting sample: key_code<=cand, key_valid=1 (1 cycle),
//             key_pressed<=1, state HELD.
//   HELD:     row frozen. On sample, no hit -> cnt=1, go RELEASE.
//             If DEBOUNCE_CNT==1 release immediately.
//             Any hit (any key) -> stay HELD.
//   RELEASE:  on sample, no hit -> cnt++. At DEBOUNCE_CNT: key_pressed<=0, SCAN, advance row.
//             Hit -> back to HELD, cnt=0.
//  Multiple keys: first row in scan order wins, then lowest column. Other keys are ignored
//    until release.
//  key_code holds its value after release until the next accepted press.
//  key_valid never asserts twice for one press; a held key never repeats.
//  Press latency: key_valid rises 1 cycle after the DEBOUNCE_CNT-th matching sample,
//    i.e. (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles after the first hit sample.
//  Reset mid-operation (any state): all outputs return to reset values immediately; scan
//    restarts at row 0. A key held through reset is re-reported as a new press.
// TESTING  (SCAN_DIV=4, DEBOUNCE_CNT=3; cycle 0 = first posedge after reset falls)
//  1. No keys, key_col=4'hF:
//     -> key_row steps 1110,1101,1011,0111 every 4 cycles and wraps; key_valid stays 0.
//  2. Hold row2/col1 (col low only while key_row==4'b1011):
//     -> first hit sample at cycle 11, key_valid pulses in cycle 20;
//        key_code=9, key_pressed=1, key_row stays 4'b1011.
//  3. Release after test 2:
//     -> key_pressed falls 1 cycle after the 3rd all-high sample; scanning resumes at row 3.
//  4. Bounce: key 5 low for 1 sample, high for the next, then stable
//     -> no pulse from the first hit; one pulse, code 5, after 3 stable samples.
//  5. Keys 6 and 7 held together -> code 6 reported once; releasing only 6 -> key_pressed stays 1.
//  6. Assert reset while in HELD -> next cycle: key_row=1110, key_pressed=0, key_code=0;
//     the key still held is reported again after deassert.

Source files
------------

// File: rtl/keypad_scanner.sv
// Row-scanning 4x4 matrix keypad reader: drives one row low at a time, synchronises and
// debounces the column lines, and reports one key code per accepted press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 10,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int unsigned     DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned     CW       = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]   CNT_DONE = CW'(DEBOUNCE_CNT);

  localparam logic [2:0] S_SCAN     = 3'd0;
  localparam logic [2:0] S_DEBOUNCE = 3'd1;
  localparam logic [2:0] S_ACCEPT   = 3'd2;
  localparam logic [2:0] S_HELD     = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;

  logic [3:0]    sync1_q, col_s_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    row_q, row_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          pressed_q, pressed_d;
  logic          sample, hit;
  logic [1:0]    col_idx;
  logic [3:0]    code_now;

  assign sample   = (div_q == DIV_LAST);
  assign hit      = (col_s_q != 4'b1111);
  assign cnt_inc  = cnt_q + 1'b1;
  assign code_now = {row_q, col_idx};

  assign key_row     = ~(4'b0001 << row_q);
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_pressed = pressed_q;

  // Lowest-index active column wins within the driven row.
  always_comb begin
    col_idx = 2'd3;
    if (!col_s_q[0])      col_idx = 2'd0;
    else if (!col_s_q[1]) col_idx = 2'd1;
    else if (!col_s_q[2]) col_idx = 2'd2;
  end

  always_comb begin
    div_d     = sample ? '0 : div_q + 1'b1;
    row_d     = row_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    pressed_d = pressed_q;
    case (state_q)
      S_SCAN: begin
        if (sample) begin
          if (hit) begin
            cand_d  = code_now;
            cnt_d   = CW'(1);
            state_d = (DEBOUNCE_CNT == 1) ? S_ACCEPT : S_DEBOUNCE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_DEBOUNCE: begin
        if (sample) begin
          if (hit && (code_now == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) state_d = S_ACCEPT;
          end else begin
            cnt_d   = '0;
            state_d = S_SCAN;
            row_d   = row_q + 1'b1;
          end
        end
      end
      // Outputs move one edge after the accepting sample, giving the documented latency.
      S_ACCEPT: begin
        code_d    = cand_q;
        valid_d   = 1'b1;
        pressed_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_HELD;
      end
      S_HELD: begin
        if (sample && !hit) begin
          if (DEBOUNCE_CNT == 1) begin
            pressed_d = 1'b0;
            cnt_d     = '0;
            state_d   = S_SCAN;
            row_d     = row_q + 1'b1;
          end else begin
            cnt_d   = CW'(1);
            state_d = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        if (sample) begin
          if (!hit) begin
            if (cnt_inc == CNT_DONE) begin
              pressed_d = 1'b0;
              cnt_d     = '0;
              state_d   = S_SCAN;
              row_d     = row_q + 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            state_d = S_HELD;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_SCAN;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= 4'b1111;
      col_s_q   <= 4'b1111;
      div_q     <= '0;
      row_q     <= '0;
      state_q   <= S_SCAN;
      cnt_q     <= '0;
      cand_q    <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      sync1_q   <= key_col;
      col_s_q   <= sync1_q;
      div_q     <= div_d;
      row_q     <= row_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3; edge 0 is the first
// rising clock edge after reset is released, and outputs are checked 1 ns after each edge.
module tb_keypad_scanner;

  logic       clock;
  logic       reset;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;

  logic [15:0] keys;
  int          edge_n;
  int          pulses;
  int          last_pulse;
  int          n_checks;
  int          n_pass;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .key_col    (key_col),
    .key_row    (key_row),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_pressed(key_pressed)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Keypad matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    key_col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!key_row[r] && keys[r*4+c]) key_col[c] = 1'b0;
      end
    end
  end

  typedef struct {
    bit          fresh;
    int          edge_n;
    logic [15:0] keys;
    logic [3:0]  row;
    logic        valid;
    logic        pressed;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s (edge %0d): got %0h, expected %0h", name, edge_n, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    edge_n++;
    if (key_valid === 1'b1) begin
      pulses++;
      last_pulse = edge_n;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    edge_n     = -1;
    pulses     = 0;
    last_pulse = -1;
    #1;
    chk("reset_row",     32'(key_row),     32'h0000000E);
    chk("reset_code",    32'(key_code),    32'h0);
    chk("reset_valid",   32'(key_valid),   32'h0);
    chk("reset_pressed", 32'(key_pressed), 32'h0);
  endtask

  task automatic run_to(input int target);
    for (int guard = 0; guard < 200 && edge_n < target; guard++) tick();
    chk("reach_edge", 32'(edge_n), 32'(target));
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset      = 1'b1;
    keys       = '0;
    edge_n     = -1;
    pulses     = 0;
    last_pulse = -1;

    // Idle scan, then key 9 held, accepted, and released.
    vecs.push_back('{1'b1,  0, 16'h0000, 4'hE, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b0,  2, 16'h0000, 4'hE, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b0,  3, 16'h0000, 4'hD, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b0,  6, 16'h0000, 4'hD, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b0,  7, 16'h0000, 4'hB, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 11, 16'h0000, 4'h7, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 14, 16'h0000, 4'h7, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 15, 16'h0000, 4'hE, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 19, 16'h0000, 4'hD, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b1, 10, 16'h0200, 4'hB, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 11, 16'h0200, 4'hB, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 19, 16'h0200, 4'hB, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 20, 16'h0200, 4'hB, 1'b1, 1'b1, 4'd9});
    vecs.push_back('{1'b0, 21, 16'h0200, 4'hB, 1'b0, 1'b1, 4'd9});
    vecs.push_back('{1'b0, 40, 16'h0200, 4'hB, 1'b0, 1'b1, 4'd9});
    vecs.push_back('{1'b0, 41, 16'h0000, 4'hB, 1'b0, 1'b1, 4'd9});
    vecs.push_back('{1'b0, 50, 16'h0000, 4'hB, 1'b0, 1'b1, 4'd9});
    vecs.push_back('{1'b0, 51, 16'h0000, 4'h7, 1'b0, 1'b0, 4'd9});
    vecs.push_back('{1'b0, 55, 16'h0000, 4'hE, 1'b0, 1'b0, 4'd9});

    foreach (vecs[i]) begin
      keys = vecs[i].keys;
      if (vecs[i].fresh) do_reset();
      run_to(vecs[i].edge_n);
      chk("tbl_row",     32'(key_row),     32'(vecs[i].row));
      chk("tbl_valid",   32'(key_valid),   32'(vecs[i].valid));
      chk("tbl_pressed", 32'(key_pressed), 32'(vecs[i].pressed));
      chk("tbl_code",    32'(key_code),    32'(vecs[i].code));
    end

    // Bounce: key 5 hit on one sample, gone on the next, then stable.
    keys = 16'h0020;
    do_reset();
    run_to(7);
    keys = 16'h0000;
    run_to(11);
    chk("bounce_row",     32'(key_row),     32'h0000000B);
    chk("bounce_pressed", 32'(key_pressed), 32'h0);
    keys = 16'h0020;
    run_to(40);
    chk("bounce_pulses",    32'(pulses),      32'd1);
    chk("bounce_pulse_at",  32'(last_pulse),  32'd36);
    chk("bounce_code",      32'(key_code),    32'd5);
    chk("bounce_pressed2",  32'(key_pressed), 32'h1);

    // Keys 6 and 7 together: 6 wins, partial release keeps the press.
    keys = 16'h00C0;
    do_reset();
    run_to(20);
    keys = 16'h0080;
    run_to(40);
    chk("multi_pulses",   32'(pulses),      32'd1);
    chk("multi_pulse_at", 32'(last_pulse),  32'd16);
    chk("multi_code",     32'(key_code),    32'd6);
    chk("multi_pressed",  32'(key_pressed), 32'h1);
    keys = 16'h0000;
    run_to(50);
    chk("multi_rel_hold", 32'(key_pressed), 32'h1);
    run_to(51);
    chk("multi_rel_done", 32'(key_pressed), 32'h0);
    chk("multi_rel_row",  32'(key_row),     32'h0000000B);

    // Reset asserted while a key is held, then the same key re-reported.
    keys = 16'h0200;
    do_reset();
    run_to(25);
    chk("held_pressed", 32'(key_pressed), 32'h1);
    chk("held_code",    32'(key_code),    32'd9);
    reset = 1'b1;
    #1;
    chk("midrst_row",     32'(key_row),     32'h0000000E);
    chk("midrst_pressed", 32'(key_pressed), 32'h0);
    chk("midrst_code",    32'(key_code),    32'h0);
    chk("midrst_valid",   32'(key_valid),   32'h0);
    do_reset();
    run_to(21);
    chk("rereport_pulses",   32'(pulses),      32'd1);
    chk("rereport_pulse_at", 32'(last_pulse),  32'd20);
    chk("rereport_code",     32'(key_code),    32'd9);
    chk("rereport_pressed",  32'(key_pressed), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
